// File: rtl/sqrt_pkg.sv
// Shared definitions for the integer square-root unit and its square/reconstruct checker.
package sqrt_pkg;

   localparam int SQ_DW = 16;

   typedef enum logic [1:0] {SQ_IDLE, SQ_CALC, SQ_ADD, SQ_DONE} sq_state_t;

   // Root width for a given radicand width.
   function automatic int sq_root_width(input int dw);
      return dw / 2;
   endfunction

endpackage

// File: rtl/sq_shift_add.sv
// One MSB-first shift-add squaring step: acc_out = (acc_in << 1) + (q_bit ? q : 0).
module sq_shift_add #(
   parameter int DW = 16,
   parameter int RW = 8
) (
   input  logic [DW:0]   acc_in,
   input  logic          q_bit,
   input  logic [RW-1:0] q,
   output logic [DW:0]   acc_out
);

   logic [DW:0] addend;

   assign addend  = q_bit ? {{(DW + 1 - RW){1'b0}}, q} : '0;
   assign acc_out = (acc_in << 1) + addend;

endmodule

// File: rtl/sqrt_square_check.sv
// Rebuilds D = root*root + rem with a sequential shift-add squarer (one root bit per cycle).
// Optional remainder check enabled by defining SQRT_SQUARE_REM_CHECK_EN.
module sqrt_square_check
   import sqrt_pkg::*;
#(
   parameter int DW = SQ_DW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [DW/2-1:0] root,
   input  logic [DW/2:0]   rem,
   output logic [DW-1:0]   D,
   output logic            ready,
   output logic            busy,
   output logic            err
);

   localparam int RW = sq_root_width(DW);
   localparam int KW = (RW > 1) ? $clog2(RW) : 1;

   sq_state_t     state_reg, state_next;
   logic [RW-1:0] root_reg;
   logic [RW:0]   rem_reg;
   logic [DW:0]   acc_reg;
   logic [DW:0]   acc_step;
   logic [DW:0]   sum_w;
   logic [KW-1:0] k_reg;
   logic [DW-1:0] d_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= SQ_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         SQ_IDLE: begin
            busy = 1'b0;
            if (start) state_next = SQ_CALC;
         end
         SQ_CALC: if (k_reg == '0) state_next = SQ_ADD;
         SQ_ADD:  state_next = SQ_DONE;
         SQ_DONE: begin
            ready      = 1'b1;
            state_next = SQ_IDLE;
         end
         default: state_next = SQ_IDLE;
      endcase
   end

   sq_shift_add #(.DW(DW), .RW(RW)) u_step (
      .acc_in  (acc_reg),
      .q_bit   (root_reg[k_reg]),
      .q       (root_reg),
      .acc_out (acc_step)
   );

   assign sum_w = acc_reg + {{(DW - RW){1'b0}}, rem_reg};

   // D is loaded on the ADD->DONE edge so it is already valid while ready is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         root_reg <= '0;
         rem_reg  <= '0;
         acc_reg  <= '0;
         k_reg    <= '0;
         d_reg    <= '0;
      end else begin
         case (state_reg)
            SQ_IDLE: if (start) begin
               root_reg <= root;
               rem_reg  <= rem;
               acc_reg  <= '0;
               k_reg    <= KW'(RW - 1);
            end
            SQ_CALC: begin
               acc_reg <= acc_step;
               k_reg   <= k_reg - KW'(1);
            end
            SQ_ADD: begin
               acc_reg <= sum_w;
               d_reg   <= sum_w[DW-1:0];
            end
            default: ;
         endcase
      end
   end

   assign D = d_reg;

`ifdef SQRT_SQUARE_REM_CHECK_EN
   logic err_reg;
   logic rem_bad;

   assign rem_bad = rem_reg > {root_reg, 1'b0};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else if (state_reg == SQ_IDLE && start) begin
         err_reg <= 1'b0;
      end else if (state_reg == SQ_ADD) begin
         err_reg <= rem_bad | sum_w[DW];
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule
